// File: rtl/vram_arbiter.sv
// Pixel RAM arbiter: VGA scan-out reads win every cycle; queued
// game-logic writes drain through a small FIFO whenever rdn is high.
module vram_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     vga_clk,
  input  logic                     clrn,
  input  logic                     rdn,
  input  logic [8:0]               row_addr,
  input  logic [9:0]               col_addr,
  output logic [11:0]              d_out,
  input  logic                     wr_valid,
  input  logic [8:0]               wr_row,
  input  logic [9:0]               wr_col,
  input  logic [11:0]              wr_data,
  output logic                     wr_ready,
  output logic [18:0]              ram_addr,
  output logic [11:0]              ram_din,
  output logic                     ram_we,
  input  logic [11:0]              ram_dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [30:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [30:0]   head;
  logic          accept;
  logic          in_range;
  logic          push;
  logic          pop;

  assign wr_ready = (level != FULL);
  assign accept   = wr_valid && wr_ready;
  assign in_range = (wr_row < 9'd480) && (wr_col < 10'd640);
  assign push     = accept && in_range;

  // level is async-reset, so ram_we drops the instant clrn falls
  assign ram_we   = rdn && (level != '0);
  assign pop      = ram_we;

  assign head     = mem[rd_ptr];
  assign ram_addr = rdn ? head[30:12] : {row_addr, col_addr};
  assign ram_din  = head[11:0];
  assign d_out    = ram_dout;

  always_ff @(posedge vga_clk) begin
    if (push) mem[wr_ptr] <= {wr_row, wr_col, wr_data};
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      err    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push && !pop: level <= level + 1'b1;
        pop && !push: level <= level - 1'b1;
        default:      level <= level;
      endcase
      if (accept && !in_range) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: model RAM, scoreboard of queued writes
// checked against every RAM write strobe.
module tb_vram_arbiter;

  logic        vga_clk = 1'b0;
  logic        clrn = 1'b0;
  logic        rdn = 1'b1;
  logic [8:0]  row_addr = '0;
  logic [9:0]  col_addr = '0;
  logic [11:0] d_out;
  logic        wr_valid = 1'b0;
  logic [8:0]  wr_row = '0;
  logic [9:0]  wr_col = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ready;
  logic [18:0] ram_addr;
  logic [11:0] ram_din;
  logic        ram_we;
  logic [11:0] ram_dout;
  logic [2:0]  level;
  logic        err;

  logic [11:0] vram [0:(1<<19)-1];
  logic [30:0] exp_q [$];
  logic [30:0] sb_e;
  int          checks = 0;
  int          failures = 0;
  bit          done = 1'b0;

  vram_arbiter #(.DEPTH(4)) dut (
    .vga_clk(vga_clk), .clrn(clrn), .rdn(rdn),
    .row_addr(row_addr), .col_addr(col_addr), .d_out(d_out),
    .wr_valid(wr_valid), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .wr_ready(wr_ready), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .level(level), .err(err)
  );

  always #5 vga_clk = ~vga_clk;

  assign ram_dout = vram[ram_addr];
  always @(posedge vga_clk) if (ram_we) vram[ram_addr] <= ram_din;

  // scoreboard: every RAM write must match the oldest accepted write
  always @(negedge vga_clk) begin
    if (clrn && ram_we) begin
      checks++;
      if (!rdn) begin
        failures++;
        $display("FAIL we_during_read ram_we=%b rdn=%b required ram_we=0", ram_we, rdn);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h required none", ram_addr, ram_din);
      end else begin
        sb_e = exp_q.pop_front();
        if ({ram_addr, ram_din} !== sb_e) begin
          failures++;
          $display("FAIL drain_order got addr=%h data=%h required addr=%h data=%h",
                   ram_addr, ram_din, sb_e[30:12], sb_e[11:0]);
        end
      end
    end
  end

  task automatic push(input logic [8:0] r, input logic [9:0] c, input logic [11:0] d);
    int n = 0;
    wr_valid = 1'b1; wr_row = r; wr_col = c; wr_data = d;
    @(negedge vga_clk);
    while (!wr_ready && n < 2000) begin
      n++;
      @(negedge vga_clk);
    end
    checks++;
    if (!wr_ready) begin
      failures++;
      $display("FAIL push_timeout wr_ready=%b required 1", wr_ready);
    end else if (r < 9'd480 && c < 10'd640) begin
      exp_q.push_back({r, c, d});
    end
    @(posedge vga_clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    clrn = 1'b0;
    repeat (2) @(posedge vga_clk);
    #1;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL rst_level got %0d required 0", level); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_we got %b required 0", ram_we); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got %b required 0", err); end
    clrn = 1'b1;
    @(negedge vga_clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got %b required 1", wr_ready); end
    @(posedge vga_clk); #1;
  endtask

  task automatic test_single;
    rdn = 1'b1;
    push(9'd10, 10'd20, 12'hF0A);
    @(negedge vga_clk);
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level1 got %0d required 1", level); end
    checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL single_we got %b required 1", ram_we); end
    checks++; if (ram_addr !== {9'd10, 10'd20}) begin failures++; $display("FAIL single_addr got %h required %h", ram_addr, {9'd10, 10'd20}); end
    checks++; if (ram_din !== 12'hF0A) begin failures++; $display("FAIL single_din got %h required f0a", ram_din); end
    @(negedge vga_clk);
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL single_level0 got %0d required 0", level); end
    checks++; if (vram[{9'd10, 10'd20}] !== 12'hF0A) begin failures++; $display("FAIL single_ram got %h required f0a", vram[{9'd10, 10'd20}]); end
    @(posedge vga_clk); #1;
  endtask

  task automatic test_range_error;
    rdn = 1'b1;
    push(9'd480, 10'd0, 12'hAAA);
    @(negedge vga_clk);
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL range_level got %0d required 0", level); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL range_we got %b required 0", ram_we); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL range_err got %b required 1", err); end
    @(posedge vga_clk); #1;
    push(9'd0, 10'd640, 12'hBBB);
    push(9'd3, 10'd7, 12'h377);
    @(negedge vga_clk);
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL range_valid_level got %0d required 1", level); end
    @(negedge vga_clk);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL range_sticky got %b required 1", err); end
    checks++; if (vram[{9'd3, 10'd7}] !== 12'h377) begin failures++; $display("FAIL range_ram got %h required 377", vram[{9'd3, 10'd7}]); end
    @(posedge vga_clk); #1;
  endtask

  task automatic test_priority;
    logic [11:0] px;
    for (int c = 0; c < 640; c++) vram[{9'd5, 10'(c)}] = 12'(c * 3) ^ 12'h5A5;
    rdn = 1'b0; row_addr = 9'd5; col_addr = 10'd0;
    for (int i = 0; i < 4; i++) push(9'(20 + i), 10'(30 + i), 12'(12'h100 + i));
    for (int c = 0; c < 640; c++) begin
      col_addr = 10'(c);
      px = 12'(c * 3) ^ 12'h5A5;
      @(negedge vga_clk);
      checks++; if (ram_addr !== {9'd5, 10'(c)}) begin failures++; $display("FAIL prio_addr col=%0d got %h required %h", c, ram_addr, {9'd5, 10'(c)}); end
      checks++; if (d_out !== px) begin failures++; $display("FAIL prio_dout col=%0d got %h required %h", c, d_out, px); end
      @(posedge vga_clk); #1;
    end
    col_addr = 10'd700;
    @(negedge vga_clk);
    checks++; if (ram_addr !== {9'd5, 10'd700}) begin failures++; $display("FAIL prio_colwrap got %h required %h", ram_addr, {9'd5, 10'd700}); end
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL prio_level got %0d required 4", level); end
    @(posedge vga_clk); #1;
    rdn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge vga_clk);
      checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL prio_drain%0d got %b required 1", k, ram_we); end
      @(posedge vga_clk); #1;
    end
    @(negedge vga_clk);
    checks++; if (ram_we !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL prio_empty we=%b level=%0d required 0 0", ram_we, level); end
    @(posedge vga_clk); #1;
  endtask

  task automatic test_full;
    rdn = 1'b0;
    for (int i = 0; i < 4; i++) push(9'(100 + i), 10'(200 + i), 12'(12'h200 + i));
    wr_valid = 1'b1; wr_row = 9'd104; wr_col = 10'd204; wr_data = 12'h204;
    @(negedge vga_clk);
    checks++; if (wr_ready !== 1'b0 || level !== 3'd4) begin failures++; $display("FAIL full_held ready=%b level=%0d required 0 4", wr_ready, level); end
    @(posedge vga_clk); #1;
    rdn = 1'b1;
    @(negedge vga_clk);
    checks++; if (ram_we !== 1'b1 || wr_ready !== 1'b0) begin failures++; $display("FAIL full_pop we=%b ready=%b required 1 0", ram_we, wr_ready); end
    @(posedge vga_clk); #1;
    @(negedge vga_clk);
    checks++; if (level !== 3'd3 || wr_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop level=%0d ready=%b required 3 1", level, wr_ready); end
    exp_q.push_back({9'd104, 10'd204, 12'h204});
    @(posedge vga_clk); #1;
    wr_valid = 1'b0;
    @(negedge vga_clk);
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL full_pushpop level=%0d required 3", level); end
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL full_drained level=%0d required 0", level); end
    @(posedge vga_clk); #1;
  endtask

  task automatic test_reset_midstream;
    vram[{9'd50, 10'd50}] = 12'h000;
    rdn = 1'b0;
    push(9'd50, 10'd50, 12'hFFF);
    push(9'd51, 10'd51, 12'hEEE);
    push(9'd52, 10'd52, 12'hDDD);
    @(negedge vga_clk);
    checks++; if (level !== 3'd3) begin failures++; $display("FAIL mid_level got %0d required 3", level); end
    @(posedge vga_clk); #1;
    rdn = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL mid_we_pre got %b required 1", ram_we); end
    clrn = 1'b0;
    #1;
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL mid_level_rst got %0d required 0", level); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL mid_we_rst got %b required 0", ram_we); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL mid_err_rst got %b required 0", err); end
    exp_q.delete();
    @(posedge vga_clk); #1;
    clrn = 1'b1;
    @(negedge vga_clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got %b required 1", wr_ready); end
    checks++; if (vram[{9'd50, 10'd50}] !== 12'h000) begin failures++; $display("FAIL mid_no_write got %h required 000", vram[{9'd50, 10'd50}]); end
    @(posedge vga_clk); #1;
  endtask

  task automatic test_gradient;
    int cyc = 0;
    done = 1'b0;
    row_addr = 9'd7;
    fork
      begin
        while (!done) begin
          @(posedge vga_clk); #1;
          cyc++;
          rdn = (cyc % 40) >= 30;
          col_addr = 10'(cyc % 40);
        end
      end
      begin
        for (int r = 0; r < 16; r++)
          for (int c = 0; c < 32; c++)
            push(9'(r), 10'(c), 12'(r * 32 + c));
        done = 1'b1;
      end
    join
    rdn = 1'b1;
    repeat (8) @(posedge vga_clk);
    @(negedge vga_clk);
    checks++; if (level !== 3'd0 || exp_q.size() != 0) begin failures++; $display("FAIL grad_drain level=%0d pending=%0d required 0 0", level, exp_q.size()); end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 32; c++) begin
        checks++;
        if (vram[{9'(r), 10'(c)}] !== 12'(r * 32 + c)) begin
          failures++;
          $display("FAIL grad_px r=%0d c=%0d got %h required %h", r, c, vram[{9'(r), 10'(c)}], 12'(r * 32 + c));
        end
      end
    @(posedge vga_clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_range_error();
    test_priority();
    test_full();
    test_reset_midstream();
    test_gradient();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port pixel RAM between VGA scan-out and game-logic pixel writes. The VGA timing generator's read has absolute priority whenever its `rdn` is low. Game-logic writes are accepted through a valid/ready handshake into a small FIFO. The FIFO drains into the RAM only on cycles when scan-out is not reading, i.e. during blanking and the front/back porches. The block sits between the VGA controller (`rdn`, `row_addr`, `col_addr`, `d_in`), the frame-buffer RAM and the game-logic draw engine.

## Interface
- `DEPTH`, default 4: write FIFO depth; power of 2, minimum 2.
- `vga_clk` in 1: 25 MHz pixel clock; all state is on the rising edge.
- `clrn` in 1: reset, asynchronous, active-low; clock `vga_clk`.
- `rdn` in 1: scan-out read request, active-low, from the VGA controller.
- `row_addr` in 9: scan-out row.
- `col_addr` in 10: scan-out column.
- `d_out` out 12: pixel to the VGA controller, format bbbb_gggg_rrrr.
- `wr_valid` in 1: write request from game logic.
- `wr_row` in 9: row of the pixel to write.
- `wr_col` in 10: column of the pixel to write.
- `wr_data` in 12: pixel value to write.
- `wr_ready` out 1: FIFO can accept a write this cycle.
- `ram_addr` out 19: RAM address, `{row[8:0], col[9:0]}`.
- `ram_din` out 12: RAM write data.
- `ram_we` out 1: RAM write enable. The RAM is synchronous-write and asynchronous-read.
- `ram_dout` in 12: RAM read data.
- `level` out log2(DEPTH)+1: current FIFO occupancy.
- `err` out 1: sticky flag for an out-of-range write.

## Operation
- **FIFO storage:** circular buffer of DEPTH entries, each 31 bits `{row, col, data}`.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - `level` is a registered count, range 0..DEPTH.
- **Accept (push):** on a rising edge when `wr_valid && wr_ready`.
  - `wr_ready = (level != DEPTH)`; it is combinational from the registered count.
  - If `wr_row >= 480` or `wr_col >= 640`, the write is accepted but not pushed. `err` sets to 1 and stays 1 until reset.
- **Drain (pop):** `ram_we = rdn && (level != 0)`.
  - On that edge the RAM writes the FIFO head and the read pointer advances.
  - One pixel is drained per non-read cycle.
- **Address mux:** all combinational.
  - `rdn == 0`: `ram_addr = {row_addr, col_addr}`.
  - Otherwise: `ram_addr = {head.row, head.col}`.
  - `ram_din = head.data`.
  - `d_out = ram_dout`.
- **Scan-out priority:** it is never stalled or delayed.
  - While `rdn == 0`, `ram_we` is 0 regardless of FIFO state.
- **Push and pop on the same edge:** `level` is unchanged and both pointers advance.
  - When full, `wr_ready` is 0, so only the pop occurs. `wr_ready` rises on the following cycle.
- **Push into an empty FIFO:** the entry becomes the head on the next cycle. It can be drained no earlier than one cycle after acceptance.
- **Scan-out column wrap:** `col_addr` values of 640 or more while `rdn` is low are forwarded unchanged. The arbiter does not range-check scan-out addresses.

## Timing
- **Reset (`clrn` low, asynchronous):**
  - Pointers = 0, `level` = 0, `err` = 0.
  - Hence `ram_we` = 0 and `wr_ready` = 1 as soon as reset deasserts.
  - `ram_addr`, `ram_din` and `d_out` follow the combinational mux.
- **Reset during a drain:** in-flight FIFO contents are discarded. No partial RAM write occurs, because `ram_we` drops asynchronously.
- **Accept-to-write latency:** minimum 1 cycle, from the accepting edge to the writing edge, when `rdn` = 1.
  - Worst case is the remainder of the active line, up to 640 cycles, plus queue position.
- **Read data:** combinational through the arbiter. `d_out` is valid in the same cycle `row_addr`/`col_addr` are presented, so the VGA controller latches it on the next edge.
- **Drain bandwidth:** 160 cycles per line are non-read. A full FIFO (DEPTH ≤ 160) always empties within one horizontal blank.

## Test plan
- **Reset:** assert `clrn` = 0 mid-stream with `level` = 3 → immediately `level` = 0, `ram_we` = 0, `err` = 0; after release, `wr_ready` = 1.
- **Single write:** `rdn` = 1, push (row 10, col 20, data 12'hF0A) → next cycle `ram_we` = 1, `ram_addr` = {9'd10, 10'd20}, `ram_din` = 12'hF0A; `level` goes 1 → 0.
- **Priority:** `rdn` = 0 for 640 cycles with 4 writes queued → `ram_we` = 0 throughout; `ram_addr` tracks `{row_addr, col_addr}`; `d_out` equals RAM contents. On `rdn` = 1, the 4 writes drain on 4 consecutive cycles in FIFO order.
- **Full:** `rdn` = 0, push 4 → `wr_ready` = 0 and the 5th `wr_valid` is held. When `rdn` rises, the pop leaves `level` = 4 → 3 and `wr_ready` = 1 the next cycle. The held write is accepted then, and the pointers wrap correctly.
- **Range error:** push row 480, col 0 → `wr_ready` handshake completes, `level` unchanged, no RAM write, `err` = 1 and stays 1 after later valid writes.
- **Full-frame regression:** connect to the VGA controller and a model RAM, and write a 640×480 gradient through the arbiter → a scoreboard confirms the RAM image matches and every displayed pixel is correct after the first complete frame.
